// File: rtl/Dmem_PKG.sv
// Shared types and helpers for the MEM-stage data memory responder:
// FSM state encoding, RV32I load/store width codes and the accept-time request check.
package Dmem_PKG;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_WAIT   = 2'd1,
    ST_ACCESS = 2'd2,
    ST_RESP   = 2'd3
  } state_e;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  // funct3[1:0] encodes the access size for both loads and stores (01 = half, 10 = word).
  function automatic logic req_error(input logic we, input logic [2:0] funct3,
                                     input logic [1:0] addr_lo);
    logic bad_f3;
    logic misal;
    if (we) begin
      bad_f3 = (funct3 != F3_B) && (funct3 != F3_H) && (funct3 != F3_W);
    end else begin
      bad_f3 = (funct3 == 3'b011) || (funct3 == 3'b110) || (funct3 == 3'b111);
    end
    case (funct3[1:0])
      2'b01:   misal = addr_lo[0];
      2'b10:   misal = (addr_lo != 2'b00);
      default: misal = 1'b0;
    endcase
    return bad_f3 || misal;
  endfunction

endpackage

// File: rtl/dmem_responder_if.sv
// Request/response bundle between the MEM stage (master) and the data memory responder (slave).
interface dmem_responder_if #(
  parameter int DATA_W     = 32,
  parameter int DM_ADDRESS = 9
);
  logic                  req_valid;
  logic                  req_ready;
  logic                  req_we;
  logic [DM_ADDRESS-1:0] req_addr;
  logic [DATA_W-1:0]     req_wdata;
  logic [2:0]            req_funct3;
  logic                  rsp_valid;
  logic [DATA_W-1:0]     rsp_rdata;
  logic                  rsp_err;

  modport master (
    output req_valid, req_we, req_addr, req_wdata, req_funct3,
    input  req_ready, rsp_valid, rsp_rdata, rsp_err
  );

  modport slave (
    input  req_valid, req_we, req_addr, req_wdata, req_funct3,
    output req_ready, rsp_valid, rsp_rdata, rsp_err
  );
endinterface

// File: rtl/dmem_lane_align.sv
// Little-endian byte-lane steering: load lane select plus sign/zero extension,
// and store byte-enable / replicated write-data generation.
module dmem_lane_align
  import Dmem_PKG::*;
#(
  parameter int DATA_W = 32
) (
  input  logic [1:0]          addr_lo_i,
  input  logic [2:0]          funct3_i,
  input  logic [DATA_W-1:0]   wdata_i,
  input  logic [DATA_W-1:0]   rword_i,
  output logic [DATA_W-1:0]   wdata_o,
  output logic [DATA_W-1:0]   rdata_o,
  output logic [DATA_W/8-1:0] be_o
);
  localparam int NB = DATA_W / 8;

  logic [7:0]  byte_s;
  logic [15:0] half_s;

  // Halfword accesses are already known to be aligned, so addr_lo[1] alone picks the half.
  always_comb begin
    byte_s = rword_i[{addr_lo_i, 3'b000} +: 8];
    half_s = rword_i[{addr_lo_i[1], 4'b0000} +: 16];
    case (funct3_i)
      F3_B:    rdata_o = {{(DATA_W-8){byte_s[7]}}, byte_s};
      F3_H:    rdata_o = {{(DATA_W-16){half_s[15]}}, half_s};
      F3_W:    rdata_o = rword_i;
      F3_BU:   rdata_o = {{(DATA_W-8){1'b0}}, byte_s};
      F3_HU:   rdata_o = {{(DATA_W-16){1'b0}}, half_s};
      default: rdata_o = {DATA_W{1'b0}};
    endcase
  end

  always_comb begin
    case (funct3_i)
      F3_B: begin
        be_o    = {{(NB-1){1'b0}}, 1'b1} << addr_lo_i;
        wdata_o = {NB{wdata_i[7:0]}};
      end
      F3_H: begin
        be_o    = {{(NB-2){1'b0}}, 2'b11} << {addr_lo_i[1], 1'b0};
        wdata_o = {(NB/2){wdata_i[15:0]}};
      end
      F3_W: begin
        be_o    = {NB{1'b1}};
        wdata_o = wdata_i;
      end
      default: begin
        be_o    = {NB{1'b0}};
        wdata_o = wdata_i;
      end
    endcase
  end

endmodule

// File: rtl/dmem_responder.sv
// Single-outstanding data memory responder: accept, optional wait states, one-cycle array
// access and a one-cycle response strobe. Array contents survive reset.
module dmem_responder
  import Dmem_PKG::*;
#(
  parameter int DATA_W      = 32,
  parameter int DM_ADDRESS  = 9,
  parameter int WAIT_STATES = 1
) (
  input logic             clk,
  input logic             reset,
  dmem_responder_if.slave bus
);
  localparam int IDX_W = DM_ADDRESS - 2;
  localparam int DEPTH = 2 ** IDX_W;
  localparam int NB    = DATA_W / 8;
  localparam logic [2:0] WS_INIT = 3'(WAIT_STATES);

  state_e                state_q, state_d;
  logic [2:0]            cnt_q, cnt_d;
  logic                  ready_q, ready_d;
  logic                  valid_q, valid_d;
  logic                  err_q, err_d;
  logic [DATA_W-1:0]     rdata_q, rdata_d;
  logic                  we_q;
  logic [DM_ADDRESS-1:0] addr_q;
  logic [DATA_W-1:0]     wdata_q;
  logic [2:0]            funct3_q;
  logic                  accept_s;
  logic                  mem_we_s;
  logic [DATA_W-1:0]     rword_q;
  logic [DATA_W-1:0]     lane_wdata_s;
  logic [DATA_W-1:0]     lane_rdata_s;
  logic [NB-1:0]         be_s;
  logic [DATA_W-1:0]     mem_q [DEPTH];

  assign bus.req_ready = ready_q;
  assign bus.rsp_valid = valid_q;
  assign bus.rsp_err   = err_q;
  assign bus.rsp_rdata = rdata_q;

  dmem_lane_align #(.DATA_W(DATA_W)) u_align (
    .addr_lo_i (addr_q[1:0]),
    .funct3_i  (funct3_q),
    .wdata_i   (wdata_q),
    .rword_i   (rword_q),
    .wdata_o   (lane_wdata_s),
    .rdata_o   (lane_rdata_s),
    .be_o      (be_s)
  );

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    err_d    = err_q;
    rdata_d  = rdata_q;
    accept_s = 1'b0;
    mem_we_s = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (bus.req_valid) begin
          accept_s = 1'b1;
          if (req_error(bus.req_we, bus.req_funct3, bus.req_addr[1:0])) begin
            state_d = ST_RESP;
            err_d   = 1'b1;
            rdata_d = {DATA_W{1'b0}};
          end else if (WAIT_STATES == 0) begin
            state_d = ST_ACCESS;
          end else begin
            state_d = ST_WAIT;
            cnt_d   = WS_INIT;
          end
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_WAIT: begin
        cnt_d = cnt_q - 3'd1;
        if (cnt_q <= 3'd1) begin
          state_d = ST_ACCESS;
        end else begin
          state_d = ST_WAIT;
        end
      end
      ST_ACCESS: begin
        mem_we_s = we_q;
        err_d    = 1'b0;
        state_d  = ST_RESP;
        if (we_q) begin
          rdata_d = {DATA_W{1'b0}};
        end else begin
          rdata_d = lane_rdata_s;
        end
      end
      ST_RESP: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
    ready_d = (state_d == ST_IDLE);
    valid_d = (state_d == ST_RESP);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= ST_IDLE;
      cnt_q   <= 3'd0;
      ready_q <= 1'b1;
      valid_q <= 1'b0;
      err_q   <= 1'b0;
      rdata_q <= {DATA_W{1'b0}};
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      ready_q <= ready_d;
      valid_q <= valid_d;
      err_q   <= err_d;
      rdata_q <= rdata_d;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      we_q     <= 1'b0;
      addr_q   <= {DM_ADDRESS{1'b0}};
      wdata_q  <= {DATA_W{1'b0}};
      funct3_q <= 3'b000;
    end else if (accept_s) begin
      we_q     <= bus.req_we;
      addr_q   <= bus.req_addr;
      wdata_q  <= bus.req_wdata;
      funct3_q <= bus.req_funct3;
    end
  end

  // Synchronous read is issued on the accept edge; nothing else can write before ACCESS.
  always_ff @(posedge clk) begin
    for (int i = 0; i < NB; i++) begin
      if (mem_we_s && be_s[i]) begin
        mem_q[addr_q[DM_ADDRESS-1:2]][i*8 +: 8] <= lane_wdata_s[i*8 +: 8];
      end
    end
    if (accept_s) begin
      rword_q <= mem_q[bus.req_addr[DM_ADDRESS-1:2]];
    end
  end

endmodule

// File: tb/tb_dmem_responder.sv
// Scoreboard bench for dmem_responder: one instance with 1 wait state, one with 3.
module tb_dmem_responder;
  typedef struct {
    logic        err;
    logic [31:0] rdata;
    int          cyc;
  } rsp_t;

  localparam logic [2:0] F_B  = 3'b000;
  localparam logic [2:0] F_H  = 3'b001;
  localparam logic [2:0] F_W  = 3'b010;
  localparam logic [2:0] F_BU = 3'b100;
  localparam logic [2:0] F_HU = 3'b101;

  logic clk   = 1'b0;
  logic reset = 1'b1;
  int checks  = 0;
  int errors  = 0;
  int edge_n  = 0;
  int pulses1 = 0;
  int pulses3 = 0;
  rsp_t sb1[$];
  rsp_t sb3[$];

  dmem_responder_if #(.DATA_W(32), .DM_ADDRESS(9)) b1 ();
  dmem_responder_if #(.DATA_W(32), .DM_ADDRESS(9)) b3 ();

  dmem_responder #(.DATA_W(32), .DM_ADDRESS(9), .WAIT_STATES(1)) dut1 (
    .clk(clk), .reset(reset), .bus(b1.slave));
  dmem_responder #(.DATA_W(32), .DM_ADDRESS(9), .WAIT_STATES(3)) dut3 (
    .clk(clk), .reset(reset), .bus(b3.slave));

  always #5 clk = ~clk;
  always @(posedge clk) edge_n <= edge_n + 1;

  always @(negedge clk) begin : mon1
    rsp_t r;
    if (b1.rsp_valid === 1'b1) begin
      pulses1++;
      checks++;
      if (sb1.size() == 0) begin
        errors++;
        $display("FAIL rsp1_unexpected: got err=%0b rdata=%h with nothing outstanding", b1.rsp_err, b1.rsp_rdata);
      end else begin
        r = sb1.pop_front();
        if (b1.rsp_err !== r.err || b1.rsp_rdata !== r.rdata || edge_n + 1 != r.cyc) begin
          errors++;
          $display("FAIL rsp1: got err=%0b rdata=%h cycle=%0d, want err=%0b rdata=%h cycle=%0d",
                   b1.rsp_err, b1.rsp_rdata, edge_n + 1, r.err, r.rdata, r.cyc);
        end
      end
    end
  end

  always @(negedge clk) begin : mon3
    rsp_t r;
    if (b3.rsp_valid === 1'b1) begin
      pulses3++;
      checks++;
      if (sb3.size() == 0) begin
        errors++;
        $display("FAIL rsp3_unexpected: got err=%0b rdata=%h with nothing outstanding", b3.rsp_err, b3.rsp_rdata);
      end else begin
        r = sb3.pop_front();
        if (b3.rsp_err !== r.err || b3.rsp_rdata !== r.rdata || edge_n + 1 != r.cyc) begin
          errors++;
          $display("FAIL rsp3: got err=%0b rdata=%h cycle=%0d, want err=%0b rdata=%h cycle=%0d",
                   b3.rsp_err, b3.rsp_rdata, edge_n + 1, r.err, r.rdata, r.cyc);
        end
      end
    end
  end

  // Drive one request, wait for its accept edge and queue the expected response.
  task automatic send(input int sel, input logic we, input logic [8:0] a, input logic [31:0] wd,
                      input logic [2:0] f3, input logic e_err, input logic [31:0] e_rd,
                      input logic keep, input logic track);
    int guard;
    int lat;
    rsp_t r;
    guard = 0;
    if (sel == 3) begin
      b3.req_valid = 1'b1; b3.req_we = we; b3.req_addr = a; b3.req_wdata = wd; b3.req_funct3 = f3;
    end else begin
      b1.req_valid = 1'b1; b1.req_we = we; b1.req_addr = a; b1.req_wdata = wd; b1.req_funct3 = f3;
    end
    while (((sel == 3) ? b3.req_ready : b1.req_ready) !== 1'b1 && guard < 64) begin
      @(negedge clk);
      guard++;
    end
    if (guard >= 64) begin
      checks++;
      errors++;
      $display("FAIL accept_timeout: dut%0d addr=%h never ready within 64 cycles", sel, a);
    end
    lat = e_err ? 1 : ((sel == 3) ? 5 : 3);
    r.err = e_err;
    r.rdata = e_rd;
    r.cyc = edge_n + 1 + lat;
    if (track) begin
      if (sel == 3) sb3.push_back(r);
      else sb1.push_back(r);
    end
    @(posedge clk);
    #1;
    if (!keep) begin
      if (sel == 3) b3.req_valid = 1'b0;
      else b1.req_valid = 1'b0;
    end
  endtask

  task automatic drain(input int sel);
    int guard;
    guard = 0;
    while (((sel == 3) ? sb3.size() : sb1.size()) > 0 && guard < 64) begin
      @(negedge clk);
      guard++;
    end
    if (guard >= 64) begin
      checks++;
      errors++;
      $display("FAIL drain_timeout: dut%0d still has responses outstanding", sel);
    end
    repeat (2) @(negedge clk);
  endtask

  task automatic test_reset();
    repeat (2) @(negedge clk);
    checks += 2;
    if (b1.req_ready !== 1'b1 || b1.rsp_valid !== 1'b0 || b1.rsp_err !== 1'b0 || b1.rsp_rdata !== 32'h0) begin
      errors++;
      $display("FAIL reset1: got ready=%0b valid=%0b err=%0b rdata=%h, want 1 0 0 00000000",
               b1.req_ready, b1.rsp_valid, b1.rsp_err, b1.rsp_rdata);
    end
    if (b3.req_ready !== 1'b1 || b3.rsp_valid !== 1'b0 || b3.rsp_err !== 1'b0 || b3.rsp_rdata !== 32'h0) begin
      errors++;
      $display("FAIL reset3: got ready=%0b valid=%0b err=%0b rdata=%h, want 1 0 0 00000000",
               b3.req_ready, b3.rsp_valid, b3.rsp_err, b3.rsp_rdata);
    end
    reset = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_word();
    @(negedge clk); send(1, 1'b1, 9'h010, 32'hDEADBEEF, F_W, 1'b0, 32'h0, 1'b0, 1'b1);
    @(negedge clk); send(1, 1'b0, 9'h010, 32'h0, F_W, 1'b0, 32'hDEADBEEF, 1'b0, 1'b1);
    drain(1);
  endtask

  task automatic test_byte();
    @(negedge clk); send(1, 1'b1, 9'h011, 32'h00000080, F_B, 1'b0, 32'h0, 1'b0, 1'b1);
    @(negedge clk); send(1, 1'b0, 9'h011, 32'h0, F_B, 1'b0, 32'hFFFFFF80, 1'b0, 1'b1);
    @(negedge clk); send(1, 1'b0, 9'h011, 32'h0, F_BU, 1'b0, 32'h00000080, 1'b0, 1'b1);
    @(negedge clk); send(1, 1'b0, 9'h010, 32'h0, F_W, 1'b0, 32'hDEAD80EF, 1'b0, 1'b1);
    @(negedge clk); send(1, 1'b0, 9'h013, 32'h0, F_B, 1'b0, 32'hFFFFFFDE, 1'b0, 1'b1);
    @(negedge clk); send(1, 1'b0, 9'h010, 32'h0, F_BU, 1'b0, 32'h000000EF, 1'b0, 1'b1);
    drain(1);
  endtask

  task automatic test_half();
    @(negedge clk); send(1, 1'b1, 9'h020, 32'h11223344, F_W, 1'b0, 32'h0, 1'b0, 1'b1);
    @(negedge clk); send(1, 1'b1, 9'h022, 32'hFFFF8001, F_H, 1'b0, 32'h0, 1'b0, 1'b1);
    @(negedge clk); send(1, 1'b0, 9'h022, 32'h0, F_H, 1'b0, 32'hFFFF8001, 1'b0, 1'b1);
    @(negedge clk); send(1, 1'b0, 9'h022, 32'h0, F_HU, 1'b0, 32'h00008001, 1'b0, 1'b1);
    @(negedge clk); send(1, 1'b0, 9'h021, 32'h0, F_H, 1'b1, 32'h0, 1'b0, 1'b1);
    @(negedge clk); send(1, 1'b0, 9'h020, 32'h0, F_W, 1'b0, 32'h80013344, 1'b0, 1'b1);
    @(negedge clk); send(1, 1'b0, 9'h012, 32'h0, F_H, 1'b0, 32'hFFFFDEAD, 1'b0, 1'b1);
    drain(1);
  endtask

  task automatic test_errors();
    @(negedge clk); send(1, 1'b1, 9'h030, 32'hCAFEF00D, F_W, 1'b0, 32'h0, 1'b0, 1'b1);
    @(negedge clk); send(1, 1'b0, 9'h030, 32'h0, F_W, 1'b0, 32'hCAFEF00D, 1'b0, 1'b1);
    @(negedge clk); send(1, 1'b1, 9'h030, 32'h0BADBEEF, 3'b011, 1'b1, 32'h0, 1'b0, 1'b1);
    @(negedge clk); send(1, 1'b1, 9'h032, 32'h0BADBEEF, F_W, 1'b1, 32'h0, 1'b0, 1'b1);
    @(negedge clk); send(1, 1'b1, 9'h031, 32'h0000BEEF, F_H, 1'b1, 32'h0, 1'b0, 1'b1);
    @(negedge clk); send(1, 1'b0, 9'h030, 32'h0, 3'b110, 1'b1, 32'h0, 1'b0, 1'b1);
    @(negedge clk); send(1, 1'b0, 9'h030, 32'h0, F_W, 1'b0, 32'hCAFEF00D, 1'b0, 1'b1);
    drain(1);
  endtask

  task automatic test_back_to_back();
    int p0;
    p0 = pulses1;
    @(negedge clk);
    send(1, 1'b0, 9'h010, 32'h0, F_W, 1'b0, 32'hDEAD80EF, 1'b1, 1'b1);
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      checks++;
      if (b1.req_ready !== 1'b0) begin
        errors++;
        $display("FAIL b2b_ready_busy: request %0d got ready=%0b, want 0", k, b1.req_ready);
      end
      if (k == 0) send(1, 1'b0, 9'h020, 32'h0, F_W, 1'b0, 32'h80013344, 1'b1, 1'b1);
      else if (k == 1) send(1, 1'b0, 9'h030, 32'h0, F_W, 1'b0, 32'hCAFEF00D, 1'b1, 1'b1);
      else if (k == 2) send(1, 1'b0, 9'h010, 32'h0, F_W, 1'b0, 32'hDEAD80EF, 1'b0, 1'b1);
    end
    drain(1);
    checks++;
    if (pulses1 - p0 != 4) begin
      errors++;
      $display("FAIL b2b_pulses: got %0d response pulses, want 4", pulses1 - p0);
    end
  endtask

  task automatic test_reset_in_wait();
    int p0;
    @(negedge clk); send(3, 1'b1, 9'h040, 32'hA5A5A5A5, F_W, 1'b0, 32'h0, 1'b0, 1'b1);
    @(negedge clk); send(3, 1'b0, 9'h040, 32'h0, F_W, 1'b0, 32'hA5A5A5A5, 1'b0, 1'b1);
    drain(3);
    p0 = pulses3;
    @(negedge clk); send(3, 1'b1, 9'h040, 32'h12345678, F_W, 1'b0, 32'h0, 1'b0, 1'b0);
    #1 reset = 1'b1;
    #1;
    checks++;
    if (b3.req_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_async_ready: got %0b, want 1 right after reset assertion", b3.req_ready);
    end
    @(negedge clk);
    checks++;
    if (b3.req_ready !== 1'b1 || b3.rsp_valid !== 1'b0 || b3.rsp_err !== 1'b0 || b3.rsp_rdata !== 32'h0) begin
      errors++;
      $display("FAIL reset_in_wait: got ready=%0b valid=%0b err=%0b rdata=%h, want 1 0 0 00000000",
               b3.req_ready, b3.rsp_valid, b3.rsp_err, b3.rsp_rdata);
    end
    repeat (2) @(negedge clk);
    reset = 1'b0;
    repeat (8) @(negedge clk);
    checks++;
    if (pulses3 != p0) begin
      errors++;
      $display("FAIL abort_no_rsp: got %0d response pulses after abort, want 0", pulses3 - p0);
    end
    @(negedge clk); send(3, 1'b0, 9'h040, 32'h0, F_W, 1'b0, 32'hA5A5A5A5, 1'b0, 1'b1);
    drain(3);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    b1.req_valid = 1'b0; b1.req_we = 1'b0; b1.req_addr = 9'h0; b1.req_wdata = 32'h0; b1.req_funct3 = 3'b000;
    b3.req_valid = 1'b0; b3.req_we = 1'b0; b3.req_addr = 9'h0; b3.req_wdata = 32'h0; b3.req_funct3 = 3'b000;
    test_reset();
    test_word();
    test_byte();
    test_half();
    test_errors();
    test_back_to_back();
    test_reset_in_wait();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
